register_file: RTL and testbench

Architectural register file with per-register rename tags for the out-of-order core. It sits downstream of the reorder buffer and consumes its in-order register writeback stream. Decode/issue reads it to obtain either a ready operand value or the ROB slot that will produce it. Decode marks destination registers busy at dispatch, and a ROB flush clears all pending renames.

---
 rtl/register_file.sv | 101 ++++++++++
 tb/tb_register_file.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags (busy + ROB slot).
// Optional same-cycle writeback bypass on the query ports: define REGFILE_WB_BYPASS_EN.
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        rename_en,
    input  logic [4:0]  rename_regid,
    input  logic [4:0]  rename_tag,
    input  logic        writeback_en,
    input  logic [4:0]  writeback_id,
    input  logic [4:0]  writeback_dependency,
    input  logic [31:0] writeback_val,
    input  logic [4:0]  query_regid1,
    input  logic [4:0]  query_regid2,
    output logic        query_busy1,
    output logic [4:0]  query_tag1,
    output logic [31:0] query_val1,
    output logic        query_busy2,
    output logic [4:0]  query_tag2,
    output logic [31:0] query_val2
);

    typedef struct packed {
        logic        busy;
        logic [4:0]  tag;
        logic [31:0] val;
    } query_t;

    logic [31:0] val_q  [32];
    logic        busy_q [32];
    logic [4:0]  tag_q  [32];

    logic wb_hit;
    logic rn_hit;

    assign wb_hit = writeback_en && (writeback_id != 5'd0);
    assign rn_hit = rename_en && (rename_regid != 5'd0) && !flush;

    // Rename is applied after writeback so a same-register rename wins the busy/tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                val_q[i]  <= 32'd0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= 5'd0;
            end
        end else begin
            if (wb_hit) begin
                val_q[writeback_id] <= writeback_val;
                if (busy_q[writeback_id] && (tag_q[writeback_id] == writeback_dependency)) begin
                    busy_q[writeback_id] <= 1'b0;
                end
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) begin
                    busy_q[i] <= 1'b0;
                end
            end
            if (rn_hit) begin
                busy_q[rename_regid] <= 1'b1;
                tag_q[rename_regid]  <= rename_tag;
            end
        end
    end

    function automatic query_t lookup(input logic [4:0] regid);
        query_t q;
        q.busy = busy_q[regid];
        q.tag  = tag_q[regid];
        q.val  = val_q[regid];
`ifdef REGFILE_WB_BYPASS_EN
        // The committing producer resolves this operand right now; forward its value.
        if (wb_hit && (writeback_id == regid) && busy_q[regid] &&
            (tag_q[regid] == writeback_dependency)) begin
            q.busy = 1'b0;
            q.val  = writeback_val;
        end
`endif
        if (regid == 5'd0) begin
            q = '0;
        end
        return q;
    endfunction

    query_t q1;
    query_t q2;

    always_comb begin
        q1 = lookup(query_regid1);
        q2 = lookup(query_regid2);
    end

    assign query_busy1 = q1.busy;
    assign query_tag1  = q1.tag;
    assign query_val1  = q1.val;
    assign query_busy2 = q2.busy;
    assign query_tag2  = q2.tag;
    assign query_val2  = q2.val;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: rename/writeback/flush interplay, x0 rules and bypass.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        rename_en;
    logic [4:0]  rename_regid;
    logic [4:0]  rename_tag;
    logic        writeback_en;
    logic [4:0]  writeback_id;
    logic [4:0]  writeback_dependency;
    logic [31:0] writeback_val;
    logic [4:0]  query_regid1;
    logic [4:0]  query_regid2;
    logic        query_busy1;
    logic [4:0]  query_tag1;
    logic [31:0] query_val1;
    logic        query_busy2;
    logic [4:0]  query_tag2;
    logic [31:0] query_val2;

    int checks;
    int errors;

    register_file dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .rename_en            (rename_en),
        .rename_regid         (rename_regid),
        .rename_tag           (rename_tag),
        .writeback_en         (writeback_en),
        .writeback_id         (writeback_id),
        .writeback_dependency (writeback_dependency),
        .writeback_val        (writeback_val),
        .query_regid1         (query_regid1),
        .query_regid2         (query_regid2),
        .query_busy1          (query_busy1),
        .query_tag1           (query_tag1),
        .query_val1           (query_val1),
        .query_busy2          (query_busy2),
        .query_tag2           (query_tag2),
        .query_val2           (query_val2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, sample point is #1 after it; all strobes drop afterwards.
    task automatic cycle();
        @(posedge clk);
        #1;
        rst          = 1'b0;
        flush        = 1'b0;
        rename_en    = 1'b0;
        writeback_en = 1'b0;
    endtask

    task automatic do_rename(input logic [4:0] r, input logic [4:0] t);
        rename_en    = 1'b1;
        rename_regid = r;
        rename_tag   = t;
    endtask

    task automatic do_writeback(input logic [4:0] r, input logic [4:0] d, input logic [31:0] v);
        writeback_en         = 1'b1;
        writeback_id         = r;
        writeback_dependency = d;
        writeback_val        = v;
    endtask

    task automatic set_query(input logic [4:0] r1, input logic [4:0] r2);
        query_regid1 = r1;
        query_regid2 = r2;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        set_query(5'd5, 5'd0);
        checks++;
        if (query_busy1 !== 1'b0 || query_val1 !== 32'd0 || query_tag1 !== 5'd0) begin
            errors++;
            $display("FAIL reset_x5 busy=%b tag=%0d val=%h required busy=0 tag=0 val=0",
                     query_busy1, query_tag1, query_val1);
        end
        checks++;
        if (query_busy2 !== 1'b0 || query_val2 !== 32'd0 || query_tag2 !== 5'd0) begin
            errors++;
            $display("FAIL reset_x0 busy=%b tag=%0d val=%h required busy=0 tag=0 val=0",
                     query_busy2, query_tag2, query_val2);
        end
        do_writeback(5'd0, 5'd0, 32'hDEADBEEF);
        do_rename(5'd0, 5'd9);
        cycle();
        set_query(5'd0, 5'd0);
        checks++;
        if (query_busy1 !== 1'b0 || query_val1 !== 32'd0 || query_tag1 !== 5'd0) begin
            errors++;
            $display("FAIL x0_write busy=%b tag=%0d val=%h required busy=0 tag=0 val=0",
                     query_busy1, query_tag1, query_val1);
        end
    endtask

    task automatic test_rename_writeback();
        do_rename(5'd3, 5'd7);
        cycle();
        set_query(5'd3, 5'd3);
        checks++;
        if (query_busy1 !== 1'b1 || query_tag1 !== 5'd7) begin
            errors++;
            $display("FAIL rename_busy busy=%b tag=%0d required busy=1 tag=7", query_busy1, query_tag1);
        end
        checks++;
        if (query_busy2 !== 1'b1 || query_tag2 !== 5'd7) begin
            errors++;
            $display("FAIL rename_busy_p2 busy=%b tag=%0d required busy=1 tag=7", query_busy2, query_tag2);
        end
        do_writeback(5'd3, 5'd7, 32'h1234);
        cycle();
        set_query(5'd3, 5'd0);
        checks++;
        if (query_busy1 !== 1'b0 || query_val1 !== 32'h1234) begin
            errors++;
            $display("FAIL wb_resolve busy=%b val=%h required busy=0 val=00001234", query_busy1, query_val1);
        end
    endtask

    task automatic test_stale_writeback();
        do_rename(5'd3, 5'd7);
        cycle();
        do_rename(5'd3, 5'd9);
        cycle();
        do_writeback(5'd3, 5'd7, 32'h55);
        cycle();
        set_query(5'd3, 5'd3);
        checks++;
        if (query_busy1 !== 1'b1 || query_tag1 !== 5'd9 || query_val1 !== 32'h55) begin
            errors++;
            $display("FAIL stale_wb busy=%b tag=%0d val=%h required busy=1 tag=9 val=00000055",
                     query_busy1, query_tag1, query_val1);
        end
        do_writeback(5'd3, 5'd9, 32'h66);
        cycle();
        set_query(5'd3, 5'd3);
        checks++;
        if (query_busy2 !== 1'b0 || query_val2 !== 32'h66) begin
            errors++;
            $display("FAIL young_wb busy=%b val=%h required busy=0 val=00000066", query_busy2, query_val2);
        end
    endtask

    task automatic test_same_cycle();
        do_rename(5'd4, 5'd1);
        cycle();
        do_rename(5'd4, 5'd2);
        do_writeback(5'd4, 5'd1, 32'hBEEF);
        cycle();
        set_query(5'd4, 5'd0);
        checks++;
        if (query_busy1 !== 1'b1 || query_tag1 !== 5'd2 || query_val1 !== 32'hBEEF) begin
            errors++;
            $display("FAIL rename_wins busy=%b tag=%0d val=%h required busy=1 tag=2 val=0000beef",
                     query_busy1, query_tag1, query_val1);
        end
    endtask

    task automatic test_query_old_mapping();
        do_rename(5'd10, 5'd11);
        set_query(5'd10, 5'd10);
        checks++;
        if (query_busy1 !== 1'b0) begin
            errors++;
            $display("FAIL pre_rename busy=%b required busy=0", query_busy1);
        end
        cycle();
        set_query(5'd10, 5'd10);
        checks++;
        if (query_busy2 !== 1'b1 || query_tag2 !== 5'd11) begin
            errors++;
            $display("FAIL post_rename busy=%b tag=%0d required busy=1 tag=11", query_busy2, query_tag2);
        end
    endtask

    task automatic test_flush();
        do_rename(5'd1, 5'd3);
        cycle();
        do_rename(5'd2, 5'd4);
        cycle();
        flush = 1'b1;
        do_writeback(5'd6, 5'd0, 32'h77);
        do_rename(5'd7, 5'd8);
        cycle();
        set_query(5'd1, 5'd2);
        checks++;
        if (query_busy1 !== 1'b0 || query_busy2 !== 1'b0) begin
            errors++;
            $display("FAIL flush_x1_x2 busy1=%b busy2=%b required 0 0", query_busy1, query_busy2);
        end
        set_query(5'd7, 5'd6);
        checks++;
        if (query_busy1 !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop_rename busy=%b required busy=0", query_busy1);
        end
        checks++;
        if (query_busy2 !== 1'b0 || query_val2 !== 32'h77) begin
            errors++;
            $display("FAIL flush_wb busy=%b val=%h required busy=0 val=00000077", query_busy2, query_val2);
        end
        set_query(5'd10, 5'd3);
        checks++;
        if (query_busy1 !== 1'b0 || query_busy2 !== 1'b0) begin
            errors++;
            $display("FAIL flush_all busy1=%b busy2=%b required 0 0", query_busy1, query_busy2);
        end
    endtask

    task automatic test_bypass();
        do_rename(5'd8, 5'd5);
        cycle();
        do_writeback(5'd8, 5'd5, 32'hAA);
        set_query(5'd8, 5'd8);
`ifdef REGFILE_WB_BYPASS_EN
        checks++;
        if (query_busy1 !== 1'b0 || query_val1 !== 32'hAA) begin
            errors++;
            $display("FAIL bypass_p1 busy=%b val=%h required busy=0 val=000000aa", query_busy1, query_val1);
        end
        checks++;
        if (query_busy2 !== 1'b0 || query_val2 !== 32'hAA) begin
            errors++;
            $display("FAIL bypass_p2 busy=%b val=%h required busy=0 val=000000aa", query_busy2, query_val2);
        end
`else
        checks++;
        if (query_busy1 !== 1'b1 || query_tag1 !== 5'd5) begin
            errors++;
            $display("FAIL nobypass_p1 busy=%b tag=%0d required busy=1 tag=5", query_busy1, query_tag1);
        end
        checks++;
        if (query_busy2 !== 1'b1 || query_tag2 !== 5'd5) begin
            errors++;
            $display("FAIL nobypass_p2 busy=%b tag=%0d required busy=1 tag=5", query_busy2, query_tag2);
        end
`endif
        cycle();
        set_query(5'd8, 5'd0);
        checks++;
        if (query_busy1 !== 1'b0 || query_val1 !== 32'hAA) begin
            errors++;
            $display("FAIL after_bypass busy=%b val=%h required busy=0 val=000000aa", query_busy1, query_val1);
        end
    endtask

    task automatic test_rst_priority();
        do_rename(5'd12, 5'd6);
        do_writeback(5'd6, 5'd0, 32'h99);
        rst = 1'b1;
        cycle();
        set_query(5'd12, 5'd6);
        checks++;
        if (query_busy1 !== 1'b0 || query_tag1 !== 5'd0) begin
            errors++;
            $display("FAIL rst_rename busy=%b tag=%0d required busy=0 tag=0", query_busy1, query_tag1);
        end
        checks++;
        if (query_val2 !== 32'd0) begin
            errors++;
            $display("FAIL rst_val val=%h required 00000000", query_val2);
        end
        set_query(5'd4, 5'd8);
        checks++;
        if (query_busy1 !== 1'b0 || query_val1 !== 32'd0 || query_val2 !== 32'd0) begin
            errors++;
            $display("FAIL rst_clear busy=%b val1=%h val2=%h required 0 0 0",
                     query_busy1, query_val1, query_val2);
        end
    endtask

    initial begin
        checks               = 0;
        errors               = 0;
        rst                  = 1'b1;
        flush                = 1'b0;
        rename_en            = 1'b0;
        rename_regid         = 5'd0;
        rename_tag           = 5'd0;
        writeback_en         = 1'b0;
        writeback_id         = 5'd0;
        writeback_dependency = 5'd0;
        writeback_val        = 32'd0;
        query_regid1         = 5'd0;
        query_regid2         = 5'd0;

        test_reset();
        test_rename_writeback();
        test_stale_writeback();
        test_same_cycle();
        test_query_old_mapping();
        test_flush();
        test_bypass();
        test_rst_priority();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
